// File: rtl/rcosc_clkdiv_pkg.sv
// -----------------------------------------------------------------------------
// rcosc_clkdiv_pkg
// Shared defaults, the channel-index width helper and the per-channel state
// record for the RC-oscillator clock-divider block.
//
// The channel state record uses STATE_DIV_W-bit fields. A channel configured
// with a narrower DIV_W zero-extends into these fields, and the unused upper
// bits are constant zero, so they reduce to nothing in hardware.
// -----------------------------------------------------------------------------
package rcosc_clkdiv_pkg;

    localparam int DEF_NUM_CH         = 4;
    localparam int DEF_DIV_W          = 16;
    localparam int DEF_STARTUP_CYCLES = 256;
    localparam int DEF_RESET_DIV      = 160;

    // Widest divisor a channel can be configured with.
    localparam int STATE_DIV_W = 32;

    // Width of a channel index. It is never below one bit, so a single-channel
    // build still has a WR_CH port that can address an invalid channel.
    function automatic int ch_idx_w(input int num_ch);
        if (num_ch <= 1) begin
            return 1;
        end else begin
            return $clog2(num_ch);
        end
    endfunction

    // Per-channel state: active divisor, pending divisor and its valid flag,
    // period counter, and the divided-clock toggle.
    typedef struct packed {
        logic [STATE_DIV_W-1:0] adiv;
        logic [STATE_DIV_W-1:0] pend;
        logic                   valid;
        logic [STATE_DIV_W-1:0] cnt;
        logic                   tog;
    } ch_state_t;

endpackage

// File: rtl/rcosc_clkdiv_ch.sv
// -----------------------------------------------------------------------------
// rcosc_clkdiv_ch
// One divided-clock channel. While it runs, it counts 0..ADIV-1 and emits a
// registered one-cycle strobe after each terminal count. A divisor write is
// held as pending. It moves into ADIV only at a period boundary, or at once if
// the channel is idle, so an output period is never cut short.
//
// Ports
//   CLK      in   oscillator clock
//   RESET    in   asynchronous active-high reset
//   ready    in   startup delay has elapsed
//   ch_en    in   channel run enable
//   wr_hit   in   a valid divisor write targets this channel this cycle
//   wr_div   in   divisor value being written
//   ce_out   out  one-cycle strobe per divided period (registered)
//   tog_out  out  50%-duty divided clock (registered)
// -----------------------------------------------------------------------------
module rcosc_clkdiv_ch
    import rcosc_clkdiv_pkg::*;
#(
    parameter int DIV_W     = DEF_DIV_W,
    parameter int RESET_DIV = DEF_RESET_DIV
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ready,
    input  logic             ch_en,
    input  logic             wr_hit,
    input  logic [DIV_W-1:0] wr_div,
    output logic             ce_out,
    output logic             tog_out
);

    localparam logic [STATE_DIV_W-1:0] ZERO_EXT  = {STATE_DIV_W{1'b0}};
    localparam logic [STATE_DIV_W-1:0] RDIV_EXT  = STATE_DIV_W'(RESET_DIV);
    localparam ch_state_t              ST_RESET  = '{adiv:  RDIV_EXT,
                                                     pend:  ZERO_EXT,
                                                     valid: 1'b0,
                                                     cnt:   ZERO_EXT,
                                                     tog:   1'b0};

    ch_state_t              st_r;
    ch_state_t              st_s;
    logic                   ce_r;
    logic                   ce_s;
    logic                   run_s;
    logic                   tc_s;
    logic                   apply_s;
    logic [STATE_DIV_W-1:0] wr_div_ext_s;
    logic [STATE_DIV_W-1:0] adiv_last_s;

    // Next-state logic: run qualification, terminal count, pending-divisor hand-over.
    always_comb begin
        st_s         = st_r;
        ce_s         = 1'b0;
        wr_div_ext_s = STATE_DIV_W'(wr_div);
        adiv_last_s  = st_r.adiv - STATE_DIV_W'(1'b1);
        run_s        = ready && ch_en && (st_r.adiv != ZERO_EXT);
        tc_s         = run_s && (st_r.cnt == adiv_last_s);
        // A write that arrives on the boundary edge itself is applied directly.
        // That way the very next period already uses it.
        apply_s      = (st_r.valid || wr_hit) && (tc_s || !run_s);

        if (wr_hit) begin
            st_s.pend = wr_div_ext_s;
        end else begin
            st_s.pend = st_r.pend;
        end

        if (apply_s) begin
            st_s.adiv  = wr_hit ? wr_div_ext_s : st_r.pend;
            st_s.valid = 1'b0;
        end else if (wr_hit) begin
            st_s.adiv  = st_r.adiv;
            st_s.valid = 1'b1;
        end else begin
            st_s.adiv  = st_r.adiv;
            st_s.valid = st_r.valid;
        end

        if (!run_s) begin
            st_s.cnt = ZERO_EXT;
            st_s.tog = 1'b0;
        end else if (tc_s) begin
            st_s.cnt = ZERO_EXT;
            st_s.tog = ~st_r.tog;
            ce_s     = 1'b1;
        end else begin
            // Increment at DIV_W so the upper state bits stay constant zero.
            st_s.cnt = STATE_DIV_W'(st_r.cnt[DIV_W-1:0] + DIV_W'(1'b1));
            st_s.tog = st_r.tog;
        end
    end

    // Channel state and strobe registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            st_r <= ST_RESET;
            ce_r <= 1'b0;
        end else begin
            st_r <= st_s;
            ce_r <= ce_s;
        end
    end

    assign ce_out  = ce_r;
    assign tog_out = st_r.tog;

endmodule

// File: rtl/rcosc_clkdiv_gen.sv
// -----------------------------------------------------------------------------
// rcosc_clkdiv_gen
// A multi-channel divided-clock-enable generator running on the RC oscillator.
// This level holds the oscillator settle counter, the divisor-write decode and
// the invalid-write error pulse. Each channel is a rcosc_clkdiv_ch instance.
//
// Ports
//   CLK      in   RC-oscillator clock
//   RESET    in   asynchronous active-high reset
//   CH_EN    in   per-channel run enable
//   WR_EN    in   divisor write strobe
//   WR_CH    in   target channel index
//   WR_DIV   in   new divisor value
//   WR_ERR   out  one-cycle pulse for a write to a nonexistent channel
//   READY    out  startup delay has elapsed
//   CE_OUT   out  per-channel one-cycle strobe per divided period
//   TOG_OUT  out  per-channel 50%-duty divided clock (data use only)
// -----------------------------------------------------------------------------
module rcosc_clkdiv_gen
    import rcosc_clkdiv_pkg::*;
#(
    parameter  int NUM_CH         = DEF_NUM_CH,
    parameter  int DIV_W          = DEF_DIV_W,
    parameter  int STARTUP_CYCLES = DEF_STARTUP_CYCLES,
    parameter  int RESET_DIV      = DEF_RESET_DIV,
    localparam int CH_W           = ch_idx_w(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] CH_EN,
    input  logic              WR_EN,
    input  logic [CH_W-1:0]   WR_CH,
    input  logic [DIV_W-1:0]  WR_DIV,
    output logic              WR_ERR,
    output logic              READY,
    output logic [NUM_CH-1:0] CE_OUT,
    output logic [NUM_CH-1:0] TOG_OUT
);

    localparam int              SU_W       = $clog2(STARTUP_CYCLES + 1);
    localparam logic [SU_W-1:0] SU_LAST    = SU_W'(STARTUP_CYCLES - 1);
    localparam int              CH_XW      = CH_W + 1;
    // The index is compared one bit wider. This keeps the range check
    // meaningful even when NUM_CH is a power of two.
    localparam logic [CH_XW-1:0] NUM_CH_EXT = CH_XW'(NUM_CH);

    logic [SU_W-1:0]   su_cnt_r;
    logic              ready_r;
    logic              wr_err_r;
    logic              wr_bad_s;
    logic [CH_XW-1:0]  wr_ch_ext_s;
    logic [NUM_CH-1:0] wr_hit_s;

    assign wr_ch_ext_s = {1'b0, WR_CH};
    assign wr_bad_s    = WR_EN && (wr_ch_ext_s >= NUM_CH_EXT);

    // Oscillator settle counter. READY rises on the STARTUP_CYCLES-th edge and then holds.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            su_cnt_r <= {SU_W{1'b0}};
            ready_r  <= 1'b0;
        end else if (!ready_r) begin
            if (su_cnt_r == SU_LAST) begin
                ready_r <= 1'b1;
            end else begin
                su_cnt_r <= su_cnt_r + SU_W'(1'b1);
            end
        end
    end

    // Registered error pulse for a write to an out-of-range channel.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_err_r <= 1'b0;
        end else begin
            wr_err_r <= wr_bad_s;
        end
    end

    assign READY  = ready_r;
    assign WR_ERR = wr_err_r;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr_hit_s[g] = WR_EN && (wr_ch_ext_s == CH_XW'(g));

        rcosc_clkdiv_ch #(
            .DIV_W     (DIV_W),
            .RESET_DIV (RESET_DIV)
        ) u_ch (
            .CLK     (CLK),
            .RESET   (RESET),
            .ready   (ready_r),
            .ch_en   (CH_EN[g]),
            .wr_hit  (wr_hit_s[g]),
            .wr_div  (WR_DIV),
            .ce_out  (CE_OUT[g]),
            .tog_out (TOG_OUT[g])
        );
    end

endmodule

// File: tb/tb_rcosc_clkdiv_gen.sv
// -----------------------------------------------------------------------------
// tb_rcosc_clkdiv_gen
// Self-checking bench for rcosc_clkdiv_gen with three channels and an
// eight-cycle startup. A behavioural model tracks the elapsed cycles of each
// channel's period and predicts every output after each clock edge.
// Directed scenarios come first, then a randomized run.
// -----------------------------------------------------------------------------
module tb_rcosc_clkdiv_gen;

    localparam int NCH  = 3;
    localparam int DW   = 16;
    localparam int SU   = 8;
    localparam int RDIV = 160;

    logic           CLK    = 1'b0;
    logic           RESET  = 1'b1;
    logic [NCH-1:0] CH_EN  = '0;
    logic           WR_EN  = 1'b0;
    logic [1:0]     WR_CH  = 2'd0;
    logic [DW-1:0]  WR_DIV = 16'd0;
    logic           WR_ERR;
    logic           READY;
    logic [NCH-1:0] CE_OUT;
    logic [NCH-1:0] TOG_OUT;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Model state
    int m_su;
    bit m_ready;
    bit m_err;
    int m_adiv [NCH];
    int m_pend [NCH];
    bit m_pv   [NCH];
    int m_el   [NCH];
    bit m_tog  [NCH];
    bit m_ce   [NCH];

    rcosc_clkdiv_gen #(
        .NUM_CH         (NCH),
        .DIV_W          (DW),
        .STARTUP_CYCLES (SU),
        .RESET_DIV      (RDIV)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .CH_EN   (CH_EN),
        .WR_EN   (WR_EN),
        .WR_CH   (WR_CH),
        .WR_DIV  (WR_DIV),
        .WR_ERR  (WR_ERR),
        .READY   (READY),
        .CE_OUT  (CE_OUT),
        .TOG_OUT (TOG_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_su    = 0;
        m_ready = 1'b0;
        m_err   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            m_adiv[i] = RDIV;
            m_pend[i] = 0;
            m_pv[i]   = 1'b0;
            m_el[i]   = 0;
            m_tog[i]  = 1'b0;
            m_ce[i]   = 1'b0;
        end
    endfunction

    // One clock edge of the reference behaviour, driven by the inputs seen at that edge.
    function automatic void model_edge(input logic [NCH-1:0] en, input logic we, input int wch, input int wdiv);
        bit rdy_old;
        bit run;
        bit hit;
        bit term;
        rdy_old = m_ready;
        if (!m_ready) begin
            m_su++;
            if (m_su == SU) m_ready = 1'b1;
        end
        m_err = we && (wch >= NCH);
        for (int i = 0; i < NCH; i++) begin
            run  = rdy_old && (((en >> i) & NCH'(1)) != '0) && (m_adiv[i] != 0);
            hit  = we && (wch == i);
            term = run && (m_el[i] + 1 == m_adiv[i]);
            if (hit) begin
                m_pend[i] = wdiv;
                m_pv[i]   = 1'b1;
            end
            m_ce[i] = term;
            if (!run) begin
                m_el[i]  = 0;
                m_tog[i] = 1'b0;
            end else if (term) begin
                m_el[i]  = 0;
                m_tog[i] = !m_tog[i];
            end else begin
                m_el[i]++;
            end
            if (m_pv[i] && (term || !run)) begin
                m_adiv[i] = m_pend[i];
                m_pv[i]   = 1'b0;
            end
        end
    endfunction

    task automatic cmp_all();
        logic [NCH-1:0] ce_e;
        logic [NCH-1:0] tog_e;
        ce_e  = '0;
        tog_e = '0;
        for (int i = 0; i < NCH; i++) begin
            ce_e  = ce_e  | (NCH'(m_ce[i])  << i);
            tog_e = tog_e | (NCH'(m_tog[i]) << i);
        end
        check("ready",  32'(READY),   32'(m_ready));
        check("wr_err", 32'(WR_ERR),  32'(m_err));
        check("ce",     32'(CE_OUT),  32'(ce_e));
        check("tog",    32'(TOG_OUT), 32'(tog_e));
    endtask

    // Apply one cycle of inputs, step the model at the edge, compare 1 ns later.
    task automatic cyc(input logic [NCH-1:0] en, input logic we, input logic [1:0] wch, input logic [DW-1:0] wdiv);
        CH_EN  = en;
        WR_EN  = we;
        WR_CH  = wch;
        WR_DIV = wdiv;
        @(posedge CLK);
        model_edge(en, we, int'(wch), int'(wdiv));
        #1;
        cmp_all();
    endtask

    task automatic idle(input logic [NCH-1:0] en, input int n);
        for (int k = 0; k < n; k++) cyc(en, 1'b0, 2'd0, 16'd0);
    endtask

    // Run until CE_OUT[ch] is seen. Returns the cycle count, or -1 if the limit runs out.
    task automatic cycles_to_ce(input int ch, input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            cyc(3'b111, 1'b0, 2'd0, 16'd0);
            if (((CE_OUT >> ch) & 3'b001) != 3'b000) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        #2 RESET = 1'b1;
        #1;
        model_reset();
        cmp_all();
        #2 RESET = 1'b0;
    endtask

    initial begin
        int ready_at;
        int ce_at;
        int n;
        int k;
        int ce0_n;
        int ce1_n;
        int tog0_n;
        logic [NCH-1:0] en;

        model_reset();
        @(posedge CLK);
        #1;
        cmp_all();
        RESET = 1'b0;

        // Startup delay and first strobe at the reset divisor.
        ready_at = -1;
        ce_at    = -1;
        for (int c = 1; c <= 200; c++) begin
            cyc(3'b111, 1'b0, 2'd0, 16'd0);
            if (READY && ready_at < 0) ready_at = c;
            if (CE_OUT[0] && ce_at < 0) begin
                ce_at = c;
                break;
            end
        end
        check("ready_delay", 32'(ready_at), 32'(SU));
        check("first_ce_gap", 32'(ce_at - ready_at), 32'(RDIV));

        // Cadence: ch0 divisor 4, ch1 divisor 1. They are loaded while idle, so they apply at once.
        cyc(3'b100, 1'b1, 2'd0, 16'd4);
        cyc(3'b100, 1'b1, 2'd1, 16'd1);
        idle(3'b111, 8);
        ce0_n  = 0;
        ce1_n  = 0;
        tog0_n = 0;
        for (int c = 0; c < 40; c++) begin
            cyc(3'b111, 1'b0, 2'd0, 16'd0);
            ce0_n  += int'(CE_OUT[0]);
            ce1_n  += int'(CE_OUT[1]);
            tog0_n += int'(TOG_OUT[0]);
        end
        check("cad_ce0", 32'(ce0_n), 32'd10);
        check("cad_ce1", 32'(ce1_n), 32'd40);
        check("cad_tog0", 32'(tog0_n), 32'd20);

        // Divisor change mid-period on ch1: 10 -> 3 written at CNT=2.
        cyc(3'b101, 1'b1, 2'd1, 16'd10);
        k = 0;
        do begin
            cyc(3'b111, 1'b0, 2'd0, 16'd0);
            k++;
        end while (m_el[1] != 2 && k < 50);
        cyc(3'b111, 1'b1, 2'd1, 16'd3);
        cycles_to_ce(1, 40, n);
        check("chg_first", 32'(n), 32'd7);
        cycles_to_ce(1, 40, n);
        check("chg_next", 32'(n), 32'd3);

        // Write on the terminal-count edge: the next period is already 3.
        cyc(3'b101, 1'b1, 2'd1, 16'd10);
        k = 0;
        do begin
            cyc(3'b111, 1'b0, 2'd0, 16'd0);
            k++;
        end while (m_el[1] != 9 && k < 50);
        cyc(3'b111, 1'b1, 2'd1, 16'd3);
        check("tc_write_ce", 32'(CE_OUT[1]), 32'd1);
        cycles_to_ce(1, 40, n);
        check("tc_write_next", 32'(n), 32'd3);

        // Invalid channel write.
        cyc(3'b111, 1'b1, 2'd3, 16'd99);
        check("wr_err_pulse", 32'(WR_ERR), 32'd1);
        cyc(3'b111, 1'b0, 2'd0, 16'd0);
        check("wr_err_clear", 32'(WR_ERR), 32'd0);

        // Last write wins on ch2: 5, then 7, both inside a 10-cycle period.
        cyc(3'b011, 1'b1, 2'd2, 16'd10);
        cyc(3'b111, 1'b1, 2'd2, 16'd5);
        cyc(3'b111, 1'b1, 2'd2, 16'd7);
        cycles_to_ce(2, 40, n);
        cycles_to_ce(2, 40, n);
        check("last_write_wins", 32'(n), 32'd7);

        // Drop CH_EN[2] mid-period, then re-enable.
        idle(3'b111, 3);
        cyc(3'b011, 1'b0, 2'd0, 16'd0);
        check("dis_ce2", 32'(CE_OUT[2]), 32'd0);
        check("dis_tog2", 32'(TOG_OUT[2]), 32'd0);
        idle(3'b011, 2);
        idle(3'b111, 20);

        // Zero divisor on ch0 stops it after its terminal count.
        cyc(3'b111, 1'b1, 2'd0, 16'd0);
        idle(3'b111, 10);
        ce0_n = 0;
        for (int c = 0; c < 10; c++) begin
            cyc(3'b111, 1'b0, 2'd0, 16'd0);
            ce0_n += int'(CE_OUT[0]);
        end
        check("zero_div_stop", 32'(ce0_n), 32'd0);
        cyc(3'b111, 1'b1, 2'd0, 16'd2);
        idle(3'b111, 10);

        // Reset mid-period with a pending write outstanding.
        cyc(3'b111, 1'b1, 2'd2, 16'd2);
        pulse_reset();
        ready_at = -1;
        ce_at    = -1;
        for (int c = 1; c <= 200; c++) begin
            cyc(3'b111, 1'b0, 2'd0, 16'd0);
            if (READY && ready_at < 0) ready_at = c;
            if (CE_OUT[2] && ce_at < 0) begin
                ce_at = c;
                break;
            end
        end
        check("rst_ready_delay", 32'(ready_at), 32'(SU));
        check("rst_ce2_gap", 32'(ce_at - ready_at), 32'(RDIV));

        // Randomized run against the model.
        en = 3'b111;
        for (int r = 0; r < 2500; r++) begin
            if ($urandom_range(0, 15) == 0) en = en ^ NCH'(32'd1 << $urandom_range(0, NCH - 1));
            if ($urandom_range(0, 599) == 0) begin
                pulse_reset();
            end else begin
                cyc(en, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 16'($urandom_range(0, 12)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
